// File: rtl/branch_predict_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : branch_predict_ctrl
// Purpose  : Direct-mapped BTB predictor with ID-stage resolution, PC
//            redirect/flush generation and saturating branch statistics.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predict_ctrl #(
    parameter int ENTRIES = 4,
    parameter int IDX_W   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_pc,
    input  logic        stall,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        id_valid,
    input  logic        id_is_branch,
    input  logic        id_taken,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_pcp4,
    input  logic [31:0] id_target,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [15:0] br_count,
    output logic [15:0] mis_count
);

    localparam int TAG_W = 32 - IDX_W - 2;
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];

    logic        r_s_pred;
    logic [31:0] r_s_target;
    logic [15:0] r_br_count;
    logic [15:0] r_mis_count;

    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic             w_if_hit;
    logic             w_pred_taken;
    logic [IDX_W-1:0] w_id_idx;
    logic [TAG_W-1:0] w_id_tag;
    logic             w_id_hit;
    logic             w_res;
    logic             w_mispredict;
    logic             w_redirect;
    logic             w_unused_bits;

    // Word-aligned PCs: the low two bits never participate in index or tag.
    assign w_unused_bits = ^{if_pc[1:0], id_pc[1:0]};

    assign w_if_idx     = if_pc[IDX_W+1:2];
    assign w_if_tag     = if_pc[31:IDX_W+2];
    assign w_if_hit     = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign w_pred_taken = w_if_hit && r_ctr[w_if_idx][1];

    assign pred_taken  = w_pred_taken;
    assign pred_target = w_pred_taken ? r_target[w_if_idx] : 32'h0;

    assign w_id_idx = id_pc[IDX_W+1:2];
    assign w_id_tag = id_pc[31:IDX_W+2];
    assign w_id_hit = r_valid[w_id_idx] && (r_tag[w_id_idx] == w_id_tag);

    assign w_res = id_valid && !stall;

    always_comb begin
        w_mispredict = 1'b0;
        if (id_is_branch && id_taken) begin
            w_mispredict = !r_s_pred || (r_s_target != id_target);
        end else begin
            // Not-taken branches and non-branches only err if we predicted taken.
            w_mispredict = r_s_pred;
        end
    end

    assign w_redirect  = w_res && w_mispredict;
    assign redirect    = w_redirect;
    assign flush       = w_redirect;
    assign redirect_pc = (id_is_branch && id_taken) ? id_target : id_pcp4;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= 32'h0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (w_res) begin
            if (id_is_branch) begin
                if (w_id_hit) begin
                    if (id_taken) begin
                        if (r_ctr[w_id_idx] != 2'b11) begin
                            r_ctr[w_id_idx] <= r_ctr[w_id_idx] + 2'b01;
                        end
                        r_target[w_id_idx] <= id_target;
                    end else if (r_ctr[w_id_idx] != 2'b00) begin
                        r_ctr[w_id_idx] <= r_ctr[w_id_idx] - 2'b01;
                    end
                end else if (id_taken) begin
                    r_valid[w_id_idx]  <= 1'b1;
                    r_tag[w_id_idx]    <= w_id_tag;
                    r_target[w_id_idx] <= id_target;
                    r_ctr[w_id_idx]    <= 2'b10;
                end
            end else if (w_id_hit) begin
                // A non-branch matching an entry means the entry is stale.
                r_valid[w_id_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s_pred   <= 1'b0;
            r_s_target <= 32'h0;
        end else if (!stall) begin
            if (w_redirect) begin
                r_s_pred   <= 1'b0;
                r_s_target <= 32'h0;
            end else begin
                r_s_pred   <= w_pred_taken;
                r_s_target <= pred_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_br_count  <= 16'h0;
            r_mis_count <= 16'h0;
        end else begin
            if (w_res && id_is_branch && (r_br_count != c_CNT_MAX)) begin
                r_br_count <= r_br_count + 16'h1;
            end
            if (w_redirect && (r_mis_count != c_CNT_MAX)) begin
                r_mis_count <= r_mis_count + 16'h1;
            end
        end
    end

    assign br_count  = r_br_count;
    assign mis_count = r_mis_count;

endmodule
`default_nettype wire
